// File: rtl/eth_reader.sv
// eth_reader -- drains a first-word-fall-through transmit FIFO into a
// byte-wide MAC client transmit interface.
//
// FIFO stream: a control word {1'b1, 21'b0, len[10:0]} is followed by
// ceil(len/4) data words {1'b0, b3, b2, b1, b0}. b0 goes out first. Any bytes
// of the last word that lie beyond len are never sent.
//
// Ports
//   CLK            single clock for all logic, MAC side included
//   reset          asynchronous, active low
//   memoryData     FIFO head word; bit 32 marks a control word
//   dataReady      memoryData holds a valid word
//   readWord       pops the FIFO head on this CLK edge (combinational)
//   TXdata         byte presented to the MAC
//   TXdataValid    qualifies TXdata
//   TXack          MAC accepted the first byte of the frame
//   TXunderrun     one-cycle abort of the current frame
//   frameSent      one-cycle pulse per frame completed without underrun
//   frameCount     completed frames, wraps
//   underrunCount  aborted frames, saturates at 255
module eth_reader #(
  parameter int MIN_GAP = 2   // idle cycles between frames, 1..15
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [32:0] memoryData,
  input  logic        dataReady,
  output logic        readWord,
  output logic [7:0]  TXdata,
  output logic        TXdataValid,
  input  logic        TXack,
  output logic        TXunderrun,
  output logic        frameSent,
  output logic [15:0] frameCount,
  output logic [7:0]  underrunCount
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] LOAD     = 3'd1;
  localparam logic [2:0] WAIT_ACK = 3'd2;
  localparam logic [2:0] SEND     = 3'd3;
  localparam logic [2:0] DRAIN    = 3'd4;
  localparam logic [2:0] GAP      = 3'd5;

  localparam logic [3:0] GAP_LAST = 4'(MIN_GAP - 1);

  logic [2:0]  state;
  logic [10:0] frameLen;     // header length, latched in IDLE/LOAD
  logic [10:0] remaining;    // bytes left, counting the one on TXdata
  logic [31:0] word;         // data word currently being serialised
  logic [1:0]  byteIdx;      // which byte of word is on TXdata
  logic [1:0]  nextIdx;
  logic [9:0]  drainWords;   // words of an aborted frame still in the FIFO
  logic [3:0]  gapCnt;
  logic        armed;        // blocks FIFO reads until the first edge after reset

  logic isCtrl;
  logic advance;
  logic atBoundary;

  assign isCtrl     = memoryData[32];
  assign nextIdx    = byteIdx + 2'd1;
  // The byte on TXdata is consumed every SEND cycle, or on the ack cycle.
  assign advance    = (state == SEND) || ((state == WAIT_ACK) && TXack);
  // Last byte of a word with more of the frame still to come: fetch now.
  assign atBoundary = (state == SEND) && (byteIdx == 2'd3) && (remaining > 11'd1);

  // readWord is qualified by dataReady in every state, so it can never pop
  // an empty FIFO. Control words are left in place at a word boundary and
  // while draining so the next frame keeps its header.
  always_comb begin
    readWord = 1'b0;
    if (armed && dataReady) begin
      case (state)
        IDLE, LOAD: readWord = 1'b1;
        SEND:       readWord = atBoundary && !isCtrl;
        DRAIN:      readWord = (drainWords != 10'd0) && !isCtrl;
        default:    readWord = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      frameLen      <= '0;
      remaining     <= '0;
      word          <= '0;
      byteIdx       <= '0;
      drainWords    <= '0;
      gapCnt        <= '0;
      armed         <= 1'b0;
      TXdata        <= 8'h00;
      TXdataValid   <= 1'b0;
      TXunderrun    <= 1'b0;
      frameSent     <= 1'b0;
      frameCount    <= '0;
      underrunCount <= '0;
    end else begin
      armed      <= 1'b1;
      frameSent  <= 1'b0;
      TXunderrun <= 1'b0;
      case (state)
        IDLE: begin
          // Stray data words are popped and dropped; len=0 headers likewise.
          if (readWord && isCtrl) begin
            frameLen <= memoryData[10:0];
            if (memoryData[10:0] != 11'd0) state <= LOAD;
          end
        end
        LOAD: begin
          if (readWord) begin
            if (isCtrl) begin
              // A second header replaces the first; the old frame never started.
              frameLen <= memoryData[10:0];
              if (memoryData[10:0] == 11'd0) state <= IDLE;
            end else begin
              word        <= memoryData[31:0];
              TXdata      <= memoryData[7:0];
              TXdataValid <= 1'b1;
              byteIdx     <= 2'd0;
              remaining   <= frameLen;
              state       <= WAIT_ACK;
            end
          end
        end
        WAIT_ACK, SEND: begin
          if (advance) begin
            if (remaining == 11'd1) begin
              TXdataValid <= 1'b0;
              frameSent   <= 1'b1;
              frameCount  <= frameCount + 16'd1;
              gapCnt      <= '0;
              state       <= GAP;
            end else if (byteIdx == 2'd3) begin
              if (readWord) begin
                word      <= memoryData[31:0];
                TXdata    <= memoryData[7:0];
                byteIdx   <= 2'd0;
                remaining <= remaining - 11'd1;
              end else begin
                // FIFO ran dry (or a header showed up early): abort the frame
                // and skip the words that still belong to it.
                TXdataValid <= 1'b0;
                TXunderrun  <= 1'b1;
                if (underrunCount != 8'hFF) underrunCount <= underrunCount + 8'd1;
                drainWords  <= 10'((12'(remaining) + 12'd2) >> 2);
                state       <= DRAIN;
              end
            end else begin
              TXdata    <= word[{nextIdx, 3'b000} +: 8];
              byteIdx   <= nextIdx;
              remaining <= remaining - 11'd1;
              state     <= SEND;
            end
          end
        end
        DRAIN: begin
          if ((drainWords == 10'd0) || (dataReady && isCtrl)) begin
            gapCnt <= '0;
            state  <= GAP;
          end else if (readWord) begin
            drainWords <= drainWords - 10'd1;
          end
        end
        GAP: begin
          if (gapCnt == GAP_LAST) state <= IDLE;
          else                    gapCnt <= gapCnt + 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
